// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the MIPS core; sequences boot, fetch handshake,
// stalls, prioritised redirects (exc > jump > branch) with a single pending slot, and halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          BOOT_CYCLES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    input  logic        halt,
    input  logic        resume,
    output logic        fetch_valid,
    output logic [1:0]  state
);
    localparam int CW = $clog2(BOOT_CYCLES + 1);
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
    localparam logic [31:0] EXC_ADDR = {EXC_VECTOR[31:2], 2'b00};

    typedef enum logic [1:0] {BOOT, RUN, WAIT, HALTED} state_t;

    state_t         st;
    logic [CW-1:0]  boot_cnt;
    logic           pend_vld;
    logic [1:0]     pend_pri;
    logic [31:0]    pend_tgt;
    logic           run, halting, advance;
    logic [1:0]     new_pri;
    logic [31:0]    new_tgt;

    assign state = st;

    // new_pri ranks the incoming redirect: 3 exc, 2 jump, 1 branch, 0 none
    always_comb begin
        run         = st == RUN || st == WAIT;
        halting     = run && halt && !exc;
        advance     = run && imem_ready && !stall && !halting;
        new_pri     = exc ? 2'd3 : jump ? 2'd2 : branch_taken ? 2'd1 : 2'd0;
        new_tgt     = exc ? EXC_ADDR : jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
        imem_req    = run && !halting;
        fetch_valid = advance;
        pc_next     = (reset || st == BOOT) ? RESET_VECTOR :
                      st == HALTED ? (exc ? EXC_ADDR : pc_cur) :
                      !advance ? pc_cur :
                      exc ? EXC_ADDR :
                      pend_vld ? pend_tgt :
                      new_pri != 2'd0 ? new_tgt : pc_cur + 32'd4;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= BOOT;
            boot_cnt <= '0;
            pend_vld <= 1'b0;
            pend_pri <= 2'd0;
            pend_tgt <= '0;
        end else if (st == BOOT) begin
            boot_cnt <= boot_cnt + CW'(1);
            if (boot_cnt == BOOT_LAST) st <= RUN;
        end else if (st == HALTED) begin
            if (exc) begin
                st       <= RUN;
                pend_vld <= 1'b0;
            end else if (resume) begin
                st <= RUN;
            end
        end else if (advance) begin
            st       <= RUN;
            pend_vld <= 1'b0;
        end else begin
            st <= halting ? HALTED : imem_ready ? RUN : WAIT;
            // a lower-priority redirect never displaces a held one
            if (new_pri != 2'd0 && (!pend_vld || new_pri >= pend_pri)) begin
                pend_vld <= 1'b1;
                pend_pri <= new_pri;
                pend_tgt <= new_tgt;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized stimulus checked every cycle
// against a behavioural next-PC model; the bench plays the PC register.
module tb_pc_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_cur = 32'h0;
    logic [31:0] pc_next;
    logic        imem_req, fetch_valid;
    logic [1:0]  state;
    logic        imem_ready, stall, branch_taken, jump, exc, halt, resume;
    logic [31:0] branch_target, jump_target;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .imem_req(imem_req), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc(exc), .halt(halt),
        .resume(resume), .fetch_valid(fetch_valid), .state(state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 boot, 1 run, 2 wait, 3 halted; held redirect with its rank
    int          m_mode = 0;
    int          m_boot = 0;
    bit          m_held = 0;
    int          m_rank = 0;
    logic [31:0] m_tgt = 0;
    logic [31:0] e_pc = 0;
    bit          e_req = 0, e_fv = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, exp);
        end
    endtask

    function automatic int rank_now();
        if (exc) return 3;
        if (jump) return 2;
        if (branch_taken) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] tgt_now();
        logic [31:0] t;
        t = exc ? 32'h80 : jump ? jump_target : branch_target;
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic model_comb();
        bit active, stopping, go;
        if (reset) begin
            m_mode = 0; m_boot = 0; m_held = 0; m_rank = 0; m_tgt = 0;
        end
        active   = (m_mode == 1 || m_mode == 2);
        stopping = active && halt && !exc;
        go       = active && imem_ready && !stall && !stopping;
        e_req    = active && !stopping;
        e_fv     = go;
        if (m_mode == 0) e_pc = 32'h0;
        else if (m_mode == 3) e_pc = exc ? 32'h80 : pc_cur;
        else if (!go) e_pc = pc_cur;
        else if (exc) e_pc = 32'h80;
        else if (m_held) e_pc = m_tgt;
        else if (rank_now() > 0) e_pc = tgt_now();
        else e_pc = pc_cur + 32'd4;
    endtask

    task automatic model_edge();
        bit active, stopping, go;
        int r;
        if (reset) begin
            m_mode = 0; m_boot = 0; m_held = 0; m_rank = 0; m_tgt = 0;
            return;
        end
        active   = (m_mode == 1 || m_mode == 2);
        stopping = active && halt && !exc;
        go       = active && imem_ready && !stall && !stopping;
        r        = rank_now();
        if (m_mode == 0) begin
            m_boot++;
            if (m_boot >= 2) m_mode = 1;
        end else if (m_mode == 3) begin
            if (exc) begin m_mode = 1; m_held = 0; end
            else if (resume) m_mode = 1;
        end else if (go) begin
            m_mode = 1; m_held = 0;
        end else begin
            if (r > 0 && (!m_held || r >= m_rank)) begin
                m_held = 1; m_rank = r; m_tgt = tgt_now();
            end
            m_mode = stopping ? 3 : (imem_ready ? 1 : 2);
        end
    endtask

    task automatic idle();
        imem_ready = 1; stall = 0; branch_taken = 0; jump = 0; exc = 0;
        halt = 0; resume = 0; branch_target = 0; jump_target = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        pc_cur = e_pc;
        idle();
    endtask

    task automatic chk();
        #1;
        model_comb();
        check("pc_next", pc_next, e_pc);
        check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
        check("state", {30'b0, state}, m_mode);
    endtask

    initial begin
        idle();
        repeat (3) begin cyc(); reset = 1; chk(); end
        check("reset_state", {30'b0, state}, 32'd0);
        check("reset_req", {31'b0, imem_req}, 32'd0);
        cyc(); reset = 0; chk();
        check("boot0_pc", pc_next, 32'h0);
        cyc(); chk();
        check("boot1_pc", pc_next, 32'h0);
        check("boot1_fv", {31'b0, fetch_valid}, 32'd0);
        cyc(); chk();
        check("run_pc4", pc_next, 32'h4);
        check("run_fv", {31'b0, fetch_valid}, 32'd1);
        repeat (3) begin cyc(); chk(); end
        cyc(); imem_ready = 0; branch_taken = 1; branch_target = 32'h40; chk();
        check("wait_hold", pc_next, 32'h10);
        cyc(); imem_ready = 0; chk();
        check("wait_state", {30'b0, state}, 32'd2);
        cyc(); imem_ready = 0; chk();
        cyc(); chk();
        check("wait_branch", pc_next, 32'h40);
        cyc(); jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300; chk();
        check("jump_over_branch", pc_next, 32'h200);
        cyc(); exc = 1; jump = 1; jump_target = 32'h400; chk();
        check("exc_over_jump", pc_next, 32'h80);
        cyc(); stall = 1; jump = 1; jump_target = 32'h200; chk();
        check("stall_hold", pc_next, 32'h80);
        cyc(); stall = 1; branch_taken = 1; branch_target = 32'h300; chk();
        cyc(); stall = 1; exc = 1; chk();
        cyc(); chk();
        check("pending_exc", pc_next, 32'h80);
        cyc(); stall = 1; jump = 1; jump_target = 32'h204; chk();
        cyc(); stall = 1; branch_taken = 1; branch_target = 32'h300; chk();
        cyc(); chk();
        check("pending_jump_kept", pc_next, 32'h204);
        cyc(); pc_cur = 32'hFFFF_FFFC; chk();
        check("wrap", pc_next, 32'h0);
        cyc(); jump = 1; jump_target = 32'h103; chk();
        check("align", pc_next, 32'h100);
        cyc(); pc_cur = 32'h20; halt = 1; chk();
        check("halt_pc", pc_next, 32'h20);
        check("halt_req", {31'b0, imem_req}, 32'd0);
        cyc(); chk();
        check("halted_state", {30'b0, state}, 32'd3);
        cyc(); resume = 1; chk();
        cyc(); chk();
        check("resume_pc", pc_next, 32'h24);
        cyc(); imem_ready = 0; chk();
        cyc(); imem_ready = 0; chk();
        check("wait_before_reset", {30'b0, state}, 32'd2);
        reset = 1; chk();
        check("reset_wait_state", {30'b0, state}, 32'd0);
        check("reset_wait_pc", pc_next, 32'h0);
        cyc(); reset = 1; chk();
        for (int i = 0; i < 4000; i++) begin
            cyc();
            reset         = ($urandom_range(0, 249) == 0);
            imem_ready    = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            exc           = ($urandom_range(0, 11) == 0);
            halt          = ($urandom_range(0, 14) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            if ($urandom_range(0, 39) == 0) pc_cur = $urandom;
            chk();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
